axi_lite_reg_slave: RTL and testbench
=====================================

// Module: axi_lite_reg_slave
// PURPOSE
//  AXI4-Lite slave endpoint that decodes and services the transactions an axi_lite_master
//  issues over axi_lite_if. Holds NUM_REGS 32-bit read/write registers at BASE_ADDR.
//  Downstream logic sees all register contents in parallel on reg_q.
//  Single outstanding write and single outstanding read. Write and read channels are independent.
// PARAMETERS
//  ADDR_WIDTH  32            address width of awaddr/araddr
//  NUM_REGS    16            number of 32-bit registers (>=1); occupies NUM_REGS*4 bytes
//  BASE_ADDR   32'h0000_0000 byte address of register 0; must be 4-byte aligned
// PORTS
//  aclk     in   1              clock, all logic on rising edge
//  areset   in   1              asynchronous active-high reset
//  awaddr   in   ADDR_WIDTH     write address
//  awvalid  in   1              write address valid
//  awready  out  1              write address ready
//  wdata    in   32             write data
//  wstrb    in   4              write byte strobes
//  wvalid   in   1              write data valid
//  wready   out  1              write data ready
//  bresp    out  2              write response: 2'b00 OKAY, 2'b10 SLVERR
//  bvalid   out  1              write response valid
//  bready   in   1              write response ready
//  araddr   in   ADDR_WIDTH     read address
//  arvalid  in   1              read address valid
//  arready  out  1              read address ready
//  rdata    out  32             read data
//  rresp    out  2              read response: 2'b00 OKAY, 2'b10 SLVERR
//  rvalid   out  1              read data valid
//  rready   in   1              read data ready
//  reg_q    out  NUM_REGS*32    register contents; reg i at bits [32*i+31:32*i]
// BEHAVIOUR
//  Reset (asynchronous, immediate):
//   - registers = 0; bvalid = rvalid = 0; bresp = rresp = 2'b00; rdata = 0.
//   - Write and read FSMs go to idle; any in-flight transaction is dropped.
//   - awready, wready and arready are forced to 0 while areset = 1.
//  Decode:
//   - Address is in range if addr >= BASE_ADDR and (addr - BASE_ADDR) < NUM_REGS*4.
//   - Register index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
//  Write FSM:
//   - States W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
//   - W_IDLE: awready = wready = 1.
//     - AW and W handshake in the same cycle: register updated on that edge -> W_RESP.
//     - AW handshake only: latch address -> W_HAVE_A.
//     - W handshake only: latch data and strobes -> W_HAVE_D.
//   - W_HAVE_A: awready = 0, wready = 1. On W handshake: write using the latched address -> W_RESP.
//   - W_HAVE_D: wready = 0, awready = 1. On AW handshake: write using the latched data -> W_RESP.
//   - Write commit: byte k of the register is updated only if wstrb[k] = 1; wstrb = 0 is legal and writes nothing.
//     bvalid is set to 1 on the commit edge, so it is visible the cycle after the final handshake.
//   - Out-of-range write: no register changes; bresp = 2'b10.
//   - W_RESP: awready = wready = 0; bvalid and bresp held stable until bready. On bvalid & bready -> W_IDLE,
//     bvalid = 0 next cycle; the next AW/W may handshake the cycle after that.
//  Read FSM:
//   - States R_IDLE, R_DATA.
//   - R_IDLE: arready = 1. On AR handshake: rdata <= register (0 if out of range), rresp <= OKAY/SLVERR,
//     rvalid <= 1 -> R_DATA. Latency is 1 cycle.
//   - R_DATA: arready = 0; rdata and rresp held stable until rready. On rvalid & rready -> R_IDLE.
//  Concurrency:
//   - A read and a write may be in flight at the same time.
//   - AR handshake on the same edge as a write commit to the same register: rdata returns the pre-write value.
//  reg_q: registered; reflects a write from the cycle after its commit edge.
// TESTING
//  1 Reset: assert areset mid-W_RESP with bvalid=1 -> bvalid=0, all readies 0, reg_q=0 immediately;
//    after release awready=wready=arready=1.
//  2 Same-cycle AW+W: awaddr=BASE+8, wdata=32'hDEADBEEF, wstrb=4'hF -> bvalid=1 next cycle, bresp=00;
//    reg_q[95:64]=DEADBEEF.
//  3 W before AW, 3-cycle gap, wstrb=4'b0101, wdata=32'h11223344, reg 0 = 32'hAAAAAAAA -> during gap wready=0;
//    after AW, reg0 = 32'hAA22AA44.
//  4 Out of range: awaddr=BASE+NUM_REGS*4 -> bresp=2'b10, no reg_q change;
//    read of same address -> rdata=0, rresp=2'b10.
//  5 Backpressure: read BASE+8 with rready low 5 cycles -> rvalid=1 and rdata=DEADBEEF held stable,
//    arready=0 throughout.
//  6 Collision: AR BASE+4 on the same edge as a write commit of 32'h5 to reg 1 (old value 32'h3) -> rdata=32'h3;
//    next read returns 32'h5.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_slave
//   AXI4-Lite slave endpoint that holds NUM_REGS 32-bit read/write registers
//   starting at byte address BASE_ADDR. All register contents are exported in
//   parallel on reg_q. One write and one read may be outstanding at a time.
//   The write and read channels run independently.
//
// Ports
//   aclk, areset        clock (rising edge) / asynchronous active-high reset
//   aw*, w*, b*         write address, write data and write response channels
//   ar*, r*             read address and read data channels
//   reg_q               register i at bits [32*i+31:32*i]
//
// Responses: 2'b00 OKAY for an in-range address, 2'b10 SLVERR otherwise.
// An out-of-range write changes nothing. An out-of-range read returns 0.
// -----------------------------------------------------------------------------
module axi_lite_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   reg_q
);

  localparam int                    IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}                     r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [31:0]           regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;

  // The unsigned compare against BASE_ADDR rejects addresses below the window
  // whose subtraction would otherwise wrap around into range.
  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off < SPAN);
  endfunction

  // Byte offset to word index; the low two address bits are ignored.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  // Readies are a pure decode of state, forced low while reset is asserted.
  assign awready = !areset && ((w_state == W_IDLE) || (w_state == W_HAVE_D));
  assign wready  = !areset && ((w_state == W_IDLE) || (w_state == W_HAVE_A));
  assign arready = !areset && (r_state == R_IDLE);

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // Write commit: picks whichever of live/latched address and data completes
  // the transaction on this edge.
  logic                  commit_en;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [31:0]           commit_data;
  logic [3:0]            commit_strb;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    commit_en   = 1'b0;
    commit_addr = awaddr;
    commit_data = wdata;
    commit_strb = wstrb;
    unique case (w_state)
      W_IDLE:   commit_en = aw_hs && w_hs;
      W_HAVE_A: begin
        commit_en   = w_hs;
        commit_addr = aw_addr_q;
      end
      W_HAVE_D: begin
        commit_en   = aw_hs;
        commit_data = w_data_q;
        commit_strb = w_strb_q;
      end
      default:  commit_en = 1'b0;
    endcase
  end

  logic            commit_hit;
  logic [IDX_W-1:0] commit_idx;
  assign commit_hit = addr_hit(commit_addr);
  assign commit_idx = addr_idx(commit_addr);

  // Write FSM and register storage.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values. A same-edge read therefore sees the old register value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state   <= W_IDLE;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      // NOTE: this array is a set of control registers visible on reg_q, not a
      // RAM, so it is reset element by element.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (commit_en) begin
        if (commit_hit) begin
          for (int k = 0; k < 4; k++)
            if (commit_strb[k]) regs[commit_idx][8*k +: 8] <= commit_data[8*k +: 8];
        end
        bvalid  <= 1'b1;
        bresp   <= commit_hit ? RESP_OKAY : RESP_SLVERR;
        w_state <= W_RESP;
      end else begin
        unique case (w_state)
          W_IDLE: begin
            if (aw_hs) begin
              aw_addr_q <= awaddr;
              w_state   <= W_HAVE_A;
            end else if (w_hs) begin
              w_data_q <= wdata;
              w_strb_q <= wstrb;
              w_state  <= W_HAVE_D;
            end
          end
          W_RESP: begin
            if (bready) begin
              bvalid  <= 1'b0;
              w_state <= W_IDLE;
            end
          end
          default: ;  // W_HAVE_A / W_HAVE_D wait for the missing half
        endcase
      end
    end
  end

  // Read FSM: one-cycle latency, data and response held until rready.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= R_IDLE;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= addr_hit(araddr) ? regs[addr_idx(araddr)] : 32'h0;
            rresp   <= addr_hit(araddr) ? RESP_OKAY : RESP_SLVERR;
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//   Directed bench for axi_lite_reg_slave with a non-zero BASE_ADDR. Inputs
//   change 1 ns after the rising edge, and outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

  localparam int          AW   = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NR*32-1:0] reg_q;
  logic [NR*32-1:0] snap;

  int checks   = 0;
  int failures = 0;

  axi_lite_reg_slave #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] rq(input int i);
    return reg_q[32*i +: 32];
  endfunction

  // Finish an outstanding write response with bready high for one edge.
  task automatic finish_b(input string tag);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, "_bvalid_clr"}, {31'b0, bvalid}, 32'd0);
  endtask

  // AW and W presented together. bvalid must rise one edge later.
  task automatic write_same(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, "_bvalid"}, {31'b0, bvalid}, 32'd1);
    check({tag, "_bresp"},  {30'b0, bresp},  {30'b0, exp_resp});
    finish_b(tag);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    araddr = addr; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    check({tag, "_rdata"},  rdata, exp_data);
    check({tag, "_rresp"},  {30'b0, rresp}, {30'b0, exp_resp});
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({tag, "_rvalid_clr"}, {31'b0, rvalid}, 32'd0);
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    #13;
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_bvalid",  {31'b0, bvalid},  32'd0);
    areset = 1'b0;
    tick();
    check("post_rst_ready", {29'b0, awready, wready, arready}, 32'd7);
    check("post_rst_reg2", rq(2), 32'h0);

    // Same-cycle AW+W into reg 2, with bvalid held through one cycle of bready low.
    awaddr = BASE + 8; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("same_bvalid", {31'b0, bvalid}, 32'd1);
    check("same_bresp",  {30'b0, bresp},  32'd0);
    check("same_reg2",   rq(2), 32'hDEAD_BEEF);
    check("same_wready_resp", {30'b0, awready, wready}, 32'd0);
    tick();
    check("same_bvalid_hold", {31'b0, bvalid}, 32'd1);
    finish_b("same");

    // W first with a 3-cycle gap before AW, using partial strobes on reg 0.
    write_same("r0init", BASE + 0, 32'hAAAA_AAAA, 4'hF, 2'b00);
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      check("gap_wready",  {31'b0, wready},  32'd0);
      check("gap_awready", {31'b0, awready}, 32'd1);
      check("gap_reg0",    rq(0), 32'hAAAA_AAAA);
      tick();
    end
    awaddr = BASE + 2; awvalid = 1'b1;   // low address bits are ignored
    tick();
    awvalid = 1'b0;
    check("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
    check("wfirst_reg0",   rq(0), 32'hAA22_AA44);
    finish_b("wfirst");

    // AW first, then W, into reg 3.
    awaddr = BASE + 12; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("afirst_wait", {30'b0, awready, wready}, 32'd1);
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("afirst_reg3", rq(3), 32'h1234_5678);
    finish_b("afirst");

    // A zero strobe is legal and leaves reg 3 untouched.
    write_same("zstrb", BASE + 12, 32'hFFFF_FFFF, 4'h0, 2'b00);
    check("zstrb_reg3", rq(3), 32'h1234_5678);

    // Out-of-range accesses at, past and below the register window.
    snap = reg_q;
    write_same("oor_w", BASE + NR*4, 32'hCAFE_F00D, 4'hF, 2'b10);
    check("oor_noeffect", {31'b0, reg_q == snap}, 32'd1);
    read_chk("oor_r",   BASE + NR*4, 32'h0, 2'b10);
    read_chk("below_r", BASE - 4,    32'h0, 2'b10);
    read_chk("last_r",  BASE + NR*4 - 4, 32'h0, 2'b00);

    // Read backpressure: rready is held low for 5 cycles.
    araddr = BASE + 8; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid",  {31'b0, rvalid},  32'd1);
      check("bp_rdata",   rdata, 32'hDEAD_BEEF);
      check("bp_arready", {31'b0, arready}, 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("bp_rvalid_clr", {31'b0, rvalid}, 32'd0);
    check("bp_arready_back", {31'b0, arready}, 32'd1);

    // Read collides with a write commit to the same register.
    write_same("r1init", BASE + 4, 32'h3, 4'hF, 2'b00);
    awaddr = BASE + 4; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = BASE + 4; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("col_rdata",  rdata, 32'h3);
    check("col_bvalid", {31'b0, bvalid}, 32'd1);
    check("col_reg1",   rq(1), 32'h5);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    read_chk("col_next", BASE + 4, 32'h5, 2'b00);

    // Asynchronous reset asserted in the middle of a write response.
    write_same("pre_rst", BASE + 20, 32'h0BAD_CAFE, 4'hF, 2'b00);
    awaddr = BASE + 24; wdata = 32'h7777_7777; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("mid_bvalid", {31'b0, bvalid}, 32'd1);
    #2 areset = 1'b1;
    #1;
    check("arst_bvalid", {31'b0, bvalid}, 32'd0);
    check("arst_ready",  {29'b0, awready, wready, arready}, 32'd0);
    check("arst_regq",   {31'b0, reg_q == '0}, 32'd1);
    tick();
    areset = 1'b0;
    #1;
    check("rel_ready",  {29'b0, awready, wready, arready}, 32'd7);
    check("rel_bvalid", {31'b0, bvalid}, 32'd0);
    read_chk("rel_read", BASE + 8, 32'h0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
